// File: rtl/led7_scan_decoder.sv
// led7_scan_decoder: rebuilds per-digit values from a multiplexed active-low 7-segment bus,
// committing each digit only after STABLE_CNT identical samples and pulsing update on change.
module led7_scan_decoder #(
    parameter int NUM_DIGITS = 4,
    parameter int STABLE_CNT = 3,
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sample_en,
    input  logic [NUM_DIGITS-1:0]   an_in,
    input  logic [6:0]              seg_in,
    output logic [4*NUM_DIGITS-1:0] digit_val,
    output logic [NUM_DIGITS-1:0]   digit_blank,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    update,
    output logic [IW-1:0]           upd_idx
);
    localparam logic [3:0] C_BLANK = 4'd10;
    localparam logic [3:0] C_ERR   = 4'd11;

    typedef enum logic [1:0] {S_EMPTY, S_TRACK, S_LOCKED} state_t;

    state_t          r_state;
    logic [IW-1:0]   r_idx;
    logic [3:0]      r_cls;
    logic [3:0]      r_cnt;

    logic [NUM_DIGITS-1:0] w_low;
    logic                  w_valid;
    logic [IW-1:0]         w_idx;
    logic [3:0]            w_cls;
    logic                  w_same;
    logic [3:0]            w_cnt_nxt;
    logic                  w_reach;
    logic                  w_commit;
    logic [3:0]            w_cur;
    logic [3:0]            w_new_val;
    logic                  w_new_blank;
    logic                  w_new_err;
    logic                  w_changed;

    always_comb begin
        case (seg_in)
            7'b0000001: w_cls = 4'd0;
            7'b1001111: w_cls = 4'd1;
            7'b0010010: w_cls = 4'd2;
            7'b0000110: w_cls = 4'd3;
            7'b1001100: w_cls = 4'd4;
            7'b0100100: w_cls = 4'd5;
            7'b0100000: w_cls = 4'd6;
            7'b0001111: w_cls = 4'd7;
            7'b0000000: w_cls = 4'd8;
            7'b0000100: w_cls = 4'd9;
            7'b1111111: w_cls = C_BLANK;
            default:    w_cls = C_ERR;
        endcase
    end

    // A sample is usable only when exactly one anode is driven low.
    always_comb begin
        w_low   = ~an_in;
        w_valid = (w_low != '0) && ((w_low & (w_low - 1'b1)) == '0);
        w_idx   = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (w_low[i]) w_idx = i[IW-1:0];
        w_same      = (r_state != S_EMPTY) && (w_idx == r_idx) && (w_cls == r_cls);
        w_cnt_nxt   = r_cnt + 4'd1;
        w_reach     = (w_cnt_nxt == 4'(STABLE_CNT));
        w_commit    = sample_en && w_valid &&
                      (w_same ? (r_state == S_TRACK && w_reach) : (STABLE_CNT == 1));
        w_cur       = digit_val[{w_idx, 2'b00} +: 4];
        w_new_val   = (w_cls < C_BLANK) ? w_cls : w_cur;
        w_new_blank = (w_cls == C_BLANK);
        w_new_err   = (w_cls == C_ERR);
        w_changed   = (w_new_val != w_cur) || (w_new_blank != digit_blank[w_idx]) ||
                      (w_new_err != digit_err[w_idx]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_EMPTY;
            r_idx       <= '0;
            r_cls       <= '0;
            r_cnt       <= '0;
            digit_val   <= '0;
            digit_blank <= '1;
            digit_err   <= '0;
            update      <= 1'b0;
            upd_idx     <= '0;
        end else begin
            update <= 1'b0;
            if (sample_en) begin
                if (!w_valid) begin
                    r_state <= S_EMPTY;
                    r_cnt   <= '0;
                end else if (w_same) begin
                    if (r_state == S_TRACK) begin
                        r_cnt <= w_cnt_nxt;
                        if (w_reach) r_state <= S_LOCKED;
                    end
                end else begin
                    r_idx   <= w_idx;
                    r_cls   <= w_cls;
                    r_cnt   <= 4'd1;
                    r_state <= (STABLE_CNT == 1) ? S_LOCKED : S_TRACK;
                end
                if (w_commit) begin
                    digit_val[{w_idx, 2'b00} +: 4] <= w_new_val;
                    digit_blank[w_idx]             <= w_new_blank;
                    digit_err[w_idx]               <= w_new_err;
                    if (w_changed) begin
                        update  <= 1'b1;
                        upd_idx <= w_idx;
                    end
                end
            end
        end
    end
endmodule

// File: doc/led7_scan_decoder.md
# led7_scan_decoder

- Receive-side counterpart of the team's binary-to-7-segment encoder.
- Monitors a multiplexed, active-low 7-segment display bus (anode selects plus segment lines) and reconstructs the value shown on each digit position.
- Each digit is committed only after a stable-sample filter passes, and every change is announced with a one-cycle update pulse.
- Used as a bench-side and on-chip checker behind display-driver logic.

## Interface
Parameters:
- NUM_DIGITS, 4: number of multiplexed digit positions (2..8).
- STABLE_CNT, 3: consecutive identical samples required before commit (1..15).

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- clk, input, 1: rising-edge clock; all inputs are synchronous to it.
- rst_n, input, 1: asynchronous active-low reset.
- sample_en, input, 1: the bus is sampled on a clk edge where this is 1.
- an_in, input, NUM_DIGITS: anode selects, active-low; bit i selects digit i.
- seg_in, input, 7: segments, active-low; bit6 = a … bit0 = g.
- digit_val, output, 4*NUM_DIGITS: committed value of digit i in bits [4i+3:4i].
- digit_blank, output, NUM_DIGITS: 1 when digit i was last committed as blank.
- digit_err, output, NUM_DIGITS: 1 when digit i was last committed as an illegal pattern.
- update, output, 1: one-cycle pulse when a committed digit changes.
- upd_idx, output, max(1,$clog2(NUM_DIGITS)): digit index that changed; valid while update=1.

## Operation
Segment classification (seg_in → class):
- 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4, 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0000100→9.
- 1111111 → BLANK.
- Any other pattern → ERR.

Sample validity:
- A sample is valid only when exactly one an_in bit is 0. Its digit index is the position of that bit.
- Zero or multiple low anodes (ghosting, dead time) make the sample invalid. An invalid sample clears the tracker to EMPTY.

Tracker FSM, advanced only on sample_en edges:
- EMPTY:
  - Valid sample → load candidate (idx, class), cnt=1, go to TRACK.
  - If STABLE_CNT=1, commit immediately and go to LOCKED.
- TRACK:
  - Sample with the same idx and class → cnt+1.
  - When cnt reaches STABLE_CNT → commit, go to LOCKED.
  - Different idx or class → reload the candidate with cnt=1 and stay in TRACK.
  - Invalid sample → EMPTY.
- LOCKED:
  - Same idx and class → hold; cnt saturates; no further commits.
  - Different valid sample → reload the candidate, go to TRACK.
  - Invalid sample → EMPTY.

Commit into slot idx:
- Class 0–9: digit_val slot = class, blank=0, err=0.
- BLANK: blank=1, err=0, digit_val slot unchanged.
- ERR: err=1, blank=0, digit_val slot unchanged.
- update pulses only if (val, blank, err) of the slot actually changes. Recommitting an identical state gives no pulse.

Other rules:
- Only one slot can commit per cycle.
- update never stays high for two cycles unless two consecutive commits both change state.
- sample_en=0 leaves all state frozen.
- Reset mid-operation: the FSM returns to EMPTY, cnt=0, and all outputs go to reset values immediately. This is asynchronous and no pulse is generated.

## Timing
Reset values:
- digit_val=0, digit_blank=all 1, digit_err=0, update=0, upd_idx=0.
- FSM=EMPTY, cnt=0.

Latency and stability:
- With sample_en held at 1 and a stable valid pattern first sampled at edge k, the commit happens at edge k+STABLE_CNT-1.
- digit_val, digit_blank, digit_err, update and upd_idx are registered and change at that same edge, so they are visible in the following cycle.
- update is high for exactly one cycle. upd_idx holds its last value when update=0.
- Outputs are stable between commits. No combinational path runs from any input to any output.

## Test plan
- Reset: assert rst_n=0 mid-TRACK → digit_blank=4'b1111, digit_val=16'h0000, update=0 immediately. Release rst_n with no sampling → no update.
- Basic commit: STABLE_CNT=3, an_in=1110, seg_in=0010010, sample_en=1 → update at the 3rd edge with upd_idx=0, digit_val[3:0]=2, digit_blank[0]=0. The 4th–10th samples produce no further pulse.
- Scan all digits: rotate an_in through digits 0–3 showing 7,3,9,1, each held 3 samples and separated by 1 sample of an_in=1111 → four update pulses with idx 0,1,2,3 and digit_val=16'h1937.
- Filter: alternate seg_in between the patterns for 5 and 6 every sample on digit 2 → no update. Then hold 5 for 3 samples → one update, digit_val[11:8]=5.
- Error and blank: commit seg_in=1111110 on digit 1 → digit_err[1]=1 with digit_val unchanged. Then commit 1111111 → digit_blank[1]=1, digit_err[1]=0, and a second pulse.
- Ghosting and gating: an_in=1100 for any count → no commit and FSM goes to EMPTY. A stable pattern with sample_en toggling 1,0,1,0,1 commits on the 3rd enabled edge.
